// File: rtl/mdr_mem_if.sv
// ---------------------------------------------------------------------------
// mdr_mem_if
//
// Memory data register (MDR) with a small handshake FSM towards memory.
// The register is loaded either from the internal bus (MDRin) or from memory
// read data at the end of a read transaction. A write transaction presents
// the register contents on mem_wdata until memory acknowledges.
//
// Parameters
//   DATA_W     width of the register and all data ports
//   TIMEOUT_W  width of the wait-timeout counter (only with MDR_TIMEOUT_EN)
//
// Ports
//   clk        clock, all state changes on the rising edge
//   clr        asynchronous active-low reset
//   BusMuxOut  internal bus data, loaded when MDRin=1 in IDLE
//   MDRin      load BusMuxOut into the register
//   rd_req     start a memory read (wins over wr_req)
//   wr_req     start a memory write of the register contents
//   Mdatain    memory read data
//   mem_ack    memory completion strobe
//   mem_rd     read request to memory (high in RD_WAIT)
//   mem_wr     write request to memory (high in WR_WAIT)
//   mem_wdata  write data, always equal to MDR_out
//   MDR_out    register contents
//   busy       high while a transaction is in progress
//   err        sticky timeout flag
//
// Configuration macro
//   MDR_TIMEOUT_EN  when defined, a wait state without mem_ack is abandoned
//                   after 2^TIMEOUT_W-1 wait cycles and err is set. When
//                   undefined, err is tied low and waits last until mem_ack.
// ---------------------------------------------------------------------------
module mdr_mem_if #(
    parameter int DATA_W    = 32,
    parameter int TIMEOUT_W = 4
) (
    input  logic              clk,
    input  logic              clr,
    input  logic [DATA_W-1:0] BusMuxOut,
    input  logic              MDRin,
    input  logic              rd_req,
    input  logic              wr_req,
    input  logic [DATA_W-1:0] Mdatain,
    input  logic              mem_ack,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] MDR_out,
    output logic              busy,
    output logic              err
);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        RD_WAIT = 2'b01,
        WR_WAIT = 2'b10
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [DATA_W-1:0] mdr_q;
    logic [DATA_W-1:0] mdr_next;
    logic              req_accept;
    logic              tmo_hit;

    // A request is only taken in IDLE; the accept edge also starts the
    // timeout window and clears a previous timeout error.
    assign req_accept = (state == IDLE) && (rd_req || wr_req);

`ifdef MDR_TIMEOUT_EN
    // The counter holds the number of unacknowledged wait cycles already
    // spent, so the last permitted wait cycle is the one where the count
    // is one below the terminal value: leaving at that edge means the
    // transaction gave up after exactly 2^TIMEOUT_W-1 wait cycles.
    localparam logic [TIMEOUT_W-1:0] TMO_LAST = TIMEOUT_W'((2 ** TIMEOUT_W) - 2);

    logic [TIMEOUT_W-1:0] tmo_cnt;
    logic                 err_q;

    assign tmo_hit = (state != IDLE) && (tmo_cnt == TMO_LAST);

    // Timeout counter and sticky error flag. mem_ack has priority over the
    // terminal count, so an ack arriving on the last wait cycle completes
    // the transaction normally without flagging an error.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            tmo_cnt <= '0;
            err_q   <= 1'b0;
        end else if (req_accept) begin
            tmo_cnt <= '0;
            err_q   <= 1'b0;
        end else if ((state != IDLE) && !mem_ack) begin
            if (tmo_hit) begin
                err_q <= 1'b1;
            end else begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end
        end
    end

    assign err = err_q;
`else
    assign tmo_hit = 1'b0;
    assign err     = 1'b0;
`endif

    // State and data register. Reset abandons any transaction in flight
    // without touching memory or loading read data.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state <= IDLE;
            mdr_q <= '0;
        end else begin
            state <= state_next;
            mdr_q <= mdr_next;
        end
    end

    // Next-state and register-load decode. Bus loads are honoured only in
    // IDLE, and a bus load on the same edge as a write request is what the
    // write then sends, since mem_wdata follows the register.
    always_comb begin
        state_next = state;
        mdr_next   = mdr_q;
        case (state)
            IDLE: begin
                if (MDRin) begin
                    mdr_next = BusMuxOut;
                end
                if (rd_req) begin
                    state_next = RD_WAIT;
                end else if (wr_req) begin
                    state_next = WR_WAIT;
                end
            end
            RD_WAIT: begin
                if (mem_ack) begin
                    mdr_next   = Mdatain;
                    state_next = IDLE;
                end else if (tmo_hit) begin
                    state_next = IDLE;
                end
            end
            WR_WAIT: begin
                if (mem_ack || tmo_hit) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Memory strobes and busy decode purely from the current state.
    assign busy      = (state != IDLE);
    assign mem_rd    = (state == RD_WAIT);
    assign mem_wr    = (state == WR_WAIT);
    assign MDR_out   = mdr_q;
    assign mem_wdata = mdr_q;

endmodule

// File: tb/tb_mdr_mem_if.sv
// ---------------------------------------------------------------------------
// tb_mdr_mem_if
//
// Directed self-checking bench for mdr_mem_if. Inputs change 1 ns after a
// rising edge and outputs are sampled at that same point, well away from
// the next active edge. With MDR_TIMEOUT_EN defined the timeout behaviour
// is exercised; otherwise the bench checks that waits persist and err
// stays low.
// ---------------------------------------------------------------------------
module tb_mdr_mem_if;

    localparam int DATA_W = 32;

    logic              clk;
    logic              clr;
    logic [DATA_W-1:0] BusMuxOut;
    logic              MDRin;
    logic              rd_req;
    logic              wr_req;
    logic [DATA_W-1:0] Mdatain;
    logic              mem_ack;
    logic              mem_rd;
    logic              mem_wr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] MDR_out;
    logic              busy;
    logic              err;

    int assertCount;
    int failCount;

    mdr_mem_if #(
        .DATA_W    (DATA_W),
        .TIMEOUT_W (4)
    ) dut (
        .clk       (clk),
        .clr       (clr),
        .BusMuxOut (BusMuxOut),
        .MDRin     (MDRin),
        .rd_req    (rd_req),
        .wr_req    (wr_req),
        .Mdatain   (Mdatain),
        .mem_ack   (mem_ack),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .mem_wdata (mem_wdata),
        .MDR_out   (MDR_out),
        .busy      (busy),
        .err       (err)
    );

    // 10 ns clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive one full set of inputs for the coming edge.
    task automatic applyStimulus(input logic rd, input logic wr, input logic load,
                                 input logic [DATA_W-1:0] bus, input logic ack,
                                 input logic [DATA_W-1:0] mdata);
        rd_req    = rd;
        wr_req    = wr;
        MDRin     = load;
        BusMuxOut = bus;
        mem_ack   = ack;
        Mdatain   = mdata;
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One comparison: counts it, and counts and reports it if it fails.
    task automatic checkOutput(input string tag, input logic [DATA_W-1:0] observed,
                               input logic [DATA_W-1:0] expected);
        assertCount++;
        assert (observed === expected)
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Convenience: check the state-decoded strobes together.
    task automatic checkStrobes(input string tag, input logic expBusy,
                                input logic expRd, input logic expWr);
        checkOutput({tag, ".busy"},   {31'd0, busy},   {31'd0, expBusy});
        checkOutput({tag, ".mem_rd"}, {31'd0, mem_rd}, {31'd0, expRd});
        checkOutput({tag, ".mem_wr"}, {31'd0, mem_wr}, {31'd0, expWr});
    endtask

    initial begin
        assertCount = 0;
        failCount   = 0;
        clr         = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);

        // Reset held across edges: everything idle and cleared.
        tick();
        tick();
        checkOutput("reset.MDR_out", MDR_out, 32'h0);
        checkOutput("reset.err", {31'd0, err}, 32'd0);
        checkStrobes("reset", 1'b0, 1'b0, 1'b0);
        #2 clr = 1'b1;
        tick();
        checkStrobes("post_reset", 1'b0, 1'b0, 1'b0);

        // Read with ack on the first wait cycle: busy for one cycle.
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        tick();
        checkStrobes("rd1.wait", 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'hCAFEF00D);
        tick();
        checkStrobes("rd1.done", 1'b0, 1'b0, 1'b0);
        checkOutput("rd1.MDR_out", MDR_out, 32'hCAFEF00D);
        checkOutput("rd1.mem_wdata", mem_wdata, 32'hCAFEF00D);

        // Bus load then write, ack after three wait cycles.
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h12345678, 1'b0, 32'h0);
        tick();
        checkOutput("load.MDR_out", MDR_out, 32'h12345678);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h99999999);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h99999999);
        for (int i = 0; i < 3; i++) begin
            checkStrobes($sformatf("wr1.wait%0d", i), 1'b1, 1'b0, 1'b1);
            checkOutput($sformatf("wr1.wdata%0d", i), mem_wdata, 32'h12345678);
            if (i == 2) mem_ack = 1'b1;
            tick();
        end
        checkStrobes("wr1.done", 1'b0, 1'b0, 1'b0);
        checkOutput("wr1.MDR_out", MDR_out, 32'h12345678);

        // Bus load on the same edge as a write request: write sends new value.
        // Issued on the first cycle busy=0 (back-to-back acceptance).
        applyStimulus(1'b0, 1'b1, 1'b1, 32'h0F0F0F0F, 1'b0, 32'h0);
        tick();
        checkStrobes("wr2.wait", 1'b1, 1'b0, 1'b1);
        checkOutput("wr2.wdata", mem_wdata, 32'h0F0F0F0F);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h77777777);
        tick();
        checkStrobes("wr2.done", 1'b0, 1'b0, 1'b0);
        checkOutput("wr2.MDR_out", MDR_out, 32'h0F0F0F0F);

        // mem_ack in IDLE has no effect.
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'hDEADDEAD);
        tick();
        checkStrobes("idle_ack", 1'b0, 1'b0, 1'b0);
        checkOutput("idle_ack.MDR_out", MDR_out, 32'h0F0F0F0F);

        // Simultaneous rd/wr: read wins; bus load while busy is ignored.
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        tick();
        checkStrobes("rdwr.wait", 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1, 32'hAAAA5555, 1'b0, 32'h0);
        tick();
        checkStrobes("rdwr.busyload", 1'b1, 1'b1, 1'b0);
        checkOutput("rdwr.MDR_out", MDR_out, 32'h0F0F0F0F);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h13572468);
        tick();
        checkStrobes("rdwr.done", 1'b0, 1'b0, 1'b0);
        checkOutput("rdwr.MDR_out2", MDR_out, 32'h13572468);

        // Asynchronous reset in the middle of a read wait.
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h11111111);
        checkStrobes("arst.pre", 1'b1, 1'b1, 1'b0);
        #2 clr = 1'b0;
        #1;
        checkStrobes("arst", 1'b0, 1'b0, 1'b0);
        checkOutput("arst.MDR_out", MDR_out, 32'h0);
        #2 clr = 1'b1;
        tick();
        checkStrobes("arst.release", 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0000BEEF);
        tick();
        checkOutput("arst.rd.MDR_out", MDR_out, 32'h0000BEEF);
        checkStrobes("arst.rd.done", 1'b0, 1'b0, 1'b0);

`ifdef MDR_TIMEOUT_EN
        // Read with no ack: gives up after 15 wait cycles, register kept.
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h55555555);
        for (int i = 0; i < 15; i++) begin
            checkOutput($sformatf("tmo.busy%0d", i), {31'd0, busy}, 32'd1);
            tick();
        end
        checkStrobes("tmo.done", 1'b0, 1'b0, 1'b0);
        checkOutput("tmo.err", {31'd0, err}, 32'd1);
        checkOutput("tmo.MDR_out", MDR_out, 32'h0000BEEF);
        tick();
        checkOutput("tmo.err_sticky", {31'd0, err}, 32'd1);

        // Next write clears err; finish it with an ack.
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        tick();
        checkOutput("tmo.err_clear", {31'd0, err}, 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0);
        tick();
        checkStrobes("tmo.wr.done", 1'b0, 1'b0, 1'b0);

        // Ack on the last permitted wait cycle completes normally.
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h00000001);
        for (int i = 0; i < 14; i++) begin
            tick();
        end
        checkStrobes("tmo_ack.last", 1'b1, 1'b1, 1'b0);
        mem_ack = 1'b1;
        tick();
        checkOutput("tmo_ack.MDR_out", MDR_out, 32'h00000001);
        checkOutput("tmo_ack.err", {31'd0, err}, 32'd0);
        checkStrobes("tmo_ack.done", 1'b0, 1'b0, 1'b0);
`else
        // Without the timeout a read waits indefinitely and err stays low.
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h00000001);
        for (int i = 0; i < 20; i++) begin
            tick();
        end
        checkStrobes("notmo.wait", 1'b1, 1'b1, 1'b0);
        checkOutput("notmo.err", {31'd0, err}, 32'd0);
        checkOutput("notmo.MDR_out", MDR_out, 32'h0000BEEF);
        mem_ack = 1'b1;
        tick();
        checkOutput("notmo.MDR_out2", MDR_out, 32'h00000001);
        checkStrobes("notmo.done", 1'b0, 1'b0, 1'b0);
`endif

        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/mdr_mem_if.md
MDR_MEM_IF -- requirements
Module: mdr_mem_if

Interface
REQ-001 Parameter: DATA_W, default 32, width of the data register and all data ports.
REQ-002 Parameter: TIMEOUT_W, default 4, width of the wait-timeout counter; used only when MDR_TIMEOUT_EN is defined.
REQ-003 Port: clk  in  1  sole clock; all state changes on the rising edge.
REQ-004 Port: clr  in  1  reset, asynchronous, active-low.
REQ-005 Port: BusMuxOut  in  DATA_W  internal bus data.
REQ-006 Port: MDRin  in  1  load BusMuxOut into the register.
REQ-007 Port: rd_req  in  1  start a memory read transaction.
REQ-008 Port: wr_req  in  1  start a memory write of the register contents.
REQ-009 Port: Mdatain  in  DATA_W  memory read data.
REQ-010 Port: mem_ack  in  1  memory completion strobe.
REQ-011 Port: mem_rd  out  1  read request to memory.
REQ-012 Port: mem_wr  out  1  write request to memory.
REQ-013 Port: mem_wdata  out  DATA_W  write data to memory; always equals MDR_out.
REQ-014 Port: MDR_out  out  DATA_W  register contents.
REQ-015 Port: busy  out  1  high while a transaction is in progress.
REQ-016 Port: err  out  1  sticky timeout flag.

Function
REQ-017 FSM states: IDLE, RD_WAIT, WR_WAIT.
REQ-018 Outputs decode from state only: busy = (state != IDLE), mem_rd = (state == RD_WAIT), mem_wr = (state == WR_WAIT).
REQ-019 IDLE, rd_req=1 -> RD_WAIT next edge; mem_rd asserts the cycle after rd_req is sampled.
REQ-020 IDLE, wr_req=1, rd_req=0 -> WR_WAIT next edge.
REQ-021 rd_req and wr_req together in IDLE: the read wins and the write is dropped.
REQ-022 MDRin=1 in IDLE loads BusMuxOut at that edge, also when a request is accepted at the same edge; a write then uses the newly loaded value.
REQ-023 MDRin, rd_req and wr_req are ignored while busy=1.
REQ-024 RD_WAIT with mem_ack=1: the register loads Mdatain and the FSM returns to IDLE at the same edge; MDR_out is valid and busy=0 in the following cycle.
REQ-025 WR_WAIT with mem_ack=1: the FSM returns to IDLE and the register is unchanged.
REQ-026 mem_ack in IDLE is ignored.
REQ-027 Minimum transaction is 2 cycles: one request cycle, then one wait cycle with ack; back-to-back requests are accepted the first cycle busy=0.

Reset
REQ-028 While clr=0: state=IDLE, register=0, err=0, timeout counter=0, mem_rd=mem_wr=0, regardless of clk.
REQ-029 Reset asserted mid-transaction abandons it immediately; no register update occurs, and the FSM starts in IDLE after release.

Configuration
REQ-030 Macro MDR_TIMEOUT_EN defined: the counter clears on entry to a wait state and increments on each wait cycle without mem_ack.
REQ-031 With the macro: at count 2^TIMEOUT_W-1 without ack, the FSM goes to IDLE, err is set, and the register is unchanged.
REQ-032 With the macro: mem_ack in the same cycle as the terminal count completes normally and does not set err.
REQ-033 With the macro: err clears at the next accepted rd_req or wr_req.
REQ-034 Macro undefined: no counter, err tied to 0, and the wait states persist until mem_ack.

Verification
REQ-035 clr=0 mid-RD_WAIT -> MDR_out=0, busy=0, mem_rd=0 asynchronously; after release, an rd_req with ack and Mdatain=0x0000BEEF -> MDR_out=0x0000BEEF.
REQ-036 MDRin=1, BusMuxOut=0x12345678, then wr_req, ack after 3 cycles -> mem_wr high 3 cycles, mem_wdata=0x12345678, MDR_out unchanged, busy low after ack.
REQ-037 rd_req, Mdatain=0xCAFEF00D, ack on first wait cycle -> MDR_out=0xCAFEF00D the next cycle; total busy=1 cycle.
REQ-038 rd_req and wr_req in the same cycle, plus MDRin=1 with BusMuxOut=0xAAAA5555 while busy -> only mem_rd asserts; register ignores the bus load.
REQ-039 MDR_TIMEOUT_EN, TIMEOUT_W=4, rd_req, no ack -> return to IDLE after 15 wait cycles, err=1, MDR_out unchanged; next wr_req -> err=0.
REQ-040 MDR_TIMEOUT_EN, ack exactly at count 15 with Mdatain=0x00000001 -> MDR_out=0x00000001, err=0.
